exec_divider: RTL and testbench
===============================

Name:
exec_divider

Overview:
- Iterative unsigned integer divider for the core's execute stage.
- Computes either quotient or remainder of two XLEN-bit operands, one quotient bit per clock (radix-2 restoring).
- Single-request, start/done pulse handshake; the execute stage stalls until output_valid.

Parameters:
- XLEN, 64, operand/result width (matches core `XLEN from core/params.svh).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; rst=1 runs).
- input_valid  input  1  start pulse; operands sampled on the rising edge where it is high and the unit is idle.
- a_in  input  XLEN  dividend, unsigned.
- b_in  input  XLEN  divisor, unsigned.
- do_rem  input  1  0 = return quotient, 1 = return remainder; sampled together with operands.
- q_out  output  XLEN  result (quotient or remainder per latched do_rem).
- output_valid  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset (rst low, async): state IDLE, output_valid=0, q_out=0, iteration counter=0, internal quotient/remainder registers=0.
- States: IDLE, BUSY.
- IDLE, input_valid=1 at edge E0: latch a_in, b_in, do_rem; clear partial remainder; counter=XLEN; go BUSY.
- BUSY, each edge: remainder = (remainder<<1) | next dividend MSB; if remainder >= divisor (XLEN+1-bit compare) subtract and shift 1 into quotient, else shift 0; decrement counter.
- After XLEN iterations (edge E0+XLEN): q_out <= do_rem ? remainder : quotient; output_valid <= 1; go IDLE.
- output_valid high for exactly one cycle (cleared on next edge); latency fixed at XLEN cycles from capture edge to output_valid high, independent of operand values.
- q_out holds its value after output_valid drops until the next result is written.
- input_valid while BUSY: ignored; operands not re-sampled; running operation unaffected.
- input_valid on the same edge that output_valid is produced: ignored (unit still BUSY); accepted from the following cycle.
- Arithmetic strictly unsigned, full XLEN width; no overflow possible.
- Divide by zero (b=0): no special path; restoring algorithm yields quotient all-ones (2^XLEN-1) and remainder = a; same latency.
- a < b: quotient 0, remainder a.
- Reset asserted mid-operation: operation aborted, outputs to reset values, no output_valid pulse.

Test Plan:
- 6/3, do_rem=0 -> output_valid after 64 cycles, q_out=2; then 1/2 -> 0; 3/3 -> 1; 15000/300 -> 50.
- 0xFFFF_FFFF_FFFF_FFEF / 0xFFFF_FFFF_FFFF_FFF0 -> q_out=0 (a<b, full-width compare with top bit set).
- 0xFFFF_FFFF_FFFF_FC17 / 1 -> q_out=0xFFFF_FFFF_FFFF_FC17.
- do_rem=1: 15007/300 -> 7; 5/0 -> 5; do_rem=0 with 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
- Handshake: output_valid low before and during BUSY, high exactly one cycle; second input_valid pulse while BUSY -> ignored, first result delivered unchanged; q_out stable afterwards.
- Drive rst low mid-division -> output_valid=0, q_out=0 immediately (asynchronous); new request after release completes correctly.

Source files
------------

// File: rtl/exec_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, quotient or remainder out.
// Result and output_valid appear XLEN cycles after the capture edge; requests are ignored while busy.
module exec_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_valid,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            do_rem,
  output logic [XLEN-1:0] q_out,
  output logic            output_valid
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            rem_sel;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // One restoring step; the compare is XLEN+1 bits wide so a shifted-out MSB is not lost.
  always_comb begin
    rem_sh  = {rem, dvd[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs};
    fits    = (rem_sh >= {1'b0, dvs});
    rem_nxt = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      quo          <= '0;
      rem          <= '0;
      rem_sel      <= 1'b0;
      q_out        <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (input_valid) begin
            dvd     <= a_in;
            dvs     <= b_in;
            rem_sel <= do_rem;
            rem     <= '0;
            quo     <= '0;
            cnt     <= CW'(XLEN);
            state   <= BUSY;
          end
        end
        BUSY: begin
          dvd <= dvd << 1;
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          // Final iteration: publish the freshly computed step directly.
          if (cnt == CW'(1)) begin
            q_out        <= rem_sel ? rem_nxt : quo_nxt;
            output_valid <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_divider.sv
// Scoreboard bench for exec_divider: expected results queued at request time, checked on output_valid.
module tb_exec_divider;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            input_valid;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            do_rem;
  logic [XLEN-1:0] q_out;
  logic            output_valid;

  int n_pass = 0;
  int n_chk  = 0;
  logic [XLEN-1:0] exp_q[$];

  exec_divider #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .a_in         (a_in),
    .b_in         (b_in),
    .do_rem       (do_rem),
    .q_out        (q_out),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic r);
    if (b == '0) return r ? a : '1;
    return r ? (a % b) : (a / b);
  endfunction

  // Scoreboard consumer: every output_valid pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (rst && output_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out", {63'd0, output_valid}, '0);
      else chk("result", q_out, exp_q.pop_front());
    end
  end

  // Issue one request; optionally pulse input_valid again 'extra_at' cycles into the operation.
  task automatic run(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic r,
                     input int extra_at);
    int lat;
    bit seen;
    logic [XLEN-1:0] e;
    e = model(a, b, r);
    @(negedge clk);
    a_in = a; b_in = b; do_rem = r; input_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 input_valid = 1'b0;
    lat = 0;
    seen = 0;
    while (!seen && lat < XLEN + 10) begin
      if (extra_at > 0 && lat == extra_at) begin
        a_in = 64'd1000; b_in = 64'd7; do_rem = ~r; input_valid = 1'b1;
      end else begin
        input_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (output_valid) seen = 1;
    end
    input_valid = 1'b0;
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("latency", 64'(lat), 64'(XLEN));
    @(posedge clk);
    #1;
    chk("pulse_width", {63'd0, output_valid}, '0);
    chk("q_hold", q_out, e);
  endtask

  initial begin
    rst = 1'b0;
    input_valid = 1'b0;
    a_in = '0; b_in = '0; do_rem = 1'b0;
    #23;
    chk("rst_ov", {63'd0, output_valid}, '0);
    chk("rst_q", q_out, '0);
    @(negedge clk);
    rst = 1'b1;

    run(64'd6, 64'd3, 1'b0, 0);
    run(64'd1, 64'd2, 1'b0, 0);
    run(64'd3, 64'd3, 1'b0, 0);
    run(64'd15000, 64'd300, 1'b0, 0);
    run(64'hFFFF_FFFF_FFFF_FFEF, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0);
    run(64'hFFFF_FFFF_FFFF_FFEF, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 0);
    run(64'hFFFF_FFFF_FFFF_FC17, 64'd1, 1'b0, 0);
    run(64'd15007, 64'd300, 1'b1, 0);
    run(64'd5, 64'd0, 1'b1, 0);
    run(64'd5, 64'd0, 1'b0, 0);

    // Extra request mid-operation and on the completion edge must both be dropped.
    run(64'd100, 64'd9, 1'b0, 10);
    run(64'd100, 64'd9, 1'b1, XLEN - 1);
    repeat (XLEN + 5) @(posedge clk);
    #1;
    chk("no_extra_result", 64'(exp_q.size()), '0);

    for (int i = 0; i < 6; i++) begin
      logic [XLEN-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      run(ra, rb, 1'(i % 3 == 0), 0);
    end

    // Asynchronous reset mid-division: outputs clear immediately, no pulse afterwards.
    @(negedge clk);
    a_in = 64'd777; b_in = 64'd5; do_rem = 1'b0; input_valid = 1'b1;
    @(posedge clk);
    #1 input_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ov", {63'd0, output_valid}, '0);
    chk("arst_q", q_out, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (XLEN + 5) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(exp_q.size()), '0);
    run(64'd1234567, 64'd1000, 1'b1, 0);
    run(64'd1234567, 64'd1000, 1'b0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
